// File: rtl/io_timer_bank_pkg.sv
// io_timer_bank_pkg: constants and types shared by the timer bank RTL and its bench.
//   - register offsets within a channel window (io_addr[1:0])
//   - CTRL / STATUS bit positions
//   - maximum channel count addressable through io_addr[3:2]
package io_timer_bank_pkg;

  localparam int NCH_MAX = 4;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_W       = 3;

  localparam int STATUS_PEND  = 0;

  // Field order matches the CTRL bit positions above (ie = bit 2 ... en = bit 0).
  typedef struct packed {
    logic ie;
    logic oneshot;
    logic en;
  } ctrl_t;

  // Per-channel decoded write strobes.
  typedef struct packed {
    logic count;
    logic reload;
    logic ctrl;
    logic status;
  } chan_wr_t;

endpackage

// File: rtl/io_timer_bank_timer_channel.sv
// timer_channel: one timer channel of io_timer_bank (COUNT/RELOAD/CTRL/PEND).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   tick            shared prescaler tick (one cycle wide)
//   wr              decoded write strobes for this channel
//   wdata           write data, already truncated to WIDTH
//   count, reload   counter and reload value
//   ctrl            {ie, oneshot, en}
//   pend            overflow pending flag
module timer_channel
  import io_timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  chan_wr_t         wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] reload,
  output ctrl_t            ctrl,
  output logic             pend
);

  logic adv;
  logic ovf;

  assign adv = tick & ctrl.en;
  // A COUNT write in the same cycle suppresses the overflow entirely.
  assign ovf = adv & (&count) & ~wr.count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wr.count) begin
      count <= wdata;
    end else if (adv) begin
      count <= (&count) ? reload : count + 1'b1;
    end
  end

  // RELOAD never touches COUNT; it is only sampled at the next overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reload <= '0;
    else if (wr.reload) reload <= wdata;
  end

  // A CTRL write wins over the one-shot EN clear of a coincident overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr.ctrl) begin
      ctrl <= ctrl_t'(wdata[CTRL_W-1:0]);
    end else if (ovf && ctrl.oneshot) begin
      ctrl.en <= 1'b0;
    end
  end

  // Set beats write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= 1'b0;
    else if (ovf) pend <= 1'b1;
    else if (wr.status && wdata[STATUS_PEND]) pend <= 1'b0;
  end

endmodule

// File: rtl/io_timer_bank.sv
// io_timer_bank: bank of NCH up-counting timers on the CPU IO bus.
// Address map: io_addr[BASE_BIT] selects the block, io_addr[3:2] the channel,
// io_addr[1:0] the register (COUNT, RELOAD, CTRL, STATUS).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   io_rd        read strobe (reads are side-effect free, so unused)
//   io_wr        write strobe
//   io_addr      IO address
//   io_dout      CPU write data
//   io_din       combinational read data, 0 when not selected (OR-mergeable)
//   irq          registered OR of PEND & IE over all channels
module io_timer_bank
  import io_timer_bank_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int WIDTH    = 16,
  parameter int DIV      = 1,
  parameter int BASE_BIT = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        irq
);

  localparam int             PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(DIV - 1);

  logic                        sel;
  logic [1:0]                  ch;
  logic [1:0]                  rsel;
  logic                        tick;
  logic [PW-1:0]               pcnt;
  logic [NCH-1:0][WIDTH-1:0]   count_q;
  logic [NCH-1:0][WIDTH-1:0]   reload_q;
  ctrl_t [NCH-1:0]             ctrl_q;
  logic [NCH-1:0]              pend_q;
  logic [NCH-1:0]              ie_q;
  chan_wr_t [NCH-1:0]          wr_v;
  logic                        unused;

  assign sel    = io_addr[BASE_BIT];
  assign ch     = io_addr[3:2];
  assign rsel   = io_addr[1:0];
  assign unused = ^{io_rd, io_addr, io_dout};

  // Prescaler: counts 0..DIV-1, tick on the terminal value, so the first
  // tick after reset lands DIV cycles later (every cycle when DIV == 1).
  assign tick = (pcnt == PMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit           = io_wr & sel & (ch == 2'(i));
    assign wr_v[i].count  = hit & (rsel == REG_COUNT);
    assign wr_v[i].reload = hit & (rsel == REG_RELOAD);
    assign wr_v[i].ctrl   = hit & (rsel == REG_CTRL);
    assign wr_v[i].status = hit & (rsel == REG_STATUS);
    assign ie_q[i]        = ctrl_q[i].ie;

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .wr     (wr_v[i]),
      .wdata  (io_dout[WIDTH-1:0]),
      .count  (count_q[i]),
      .reload (reload_q[i]),
      .ctrl   (ctrl_q[i]),
      .pend   (pend_q[i])
    );
  end

  // Channel indices >= NCH never match, so they read 0.
  always_comb begin
    io_din = '0;
    if (sel) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch == 2'(i)) begin
          case (rsel)
            REG_COUNT:  io_din = 16'(count_q[i]);
            REG_RELOAD: io_din = 16'(reload_q[i]);
            REG_CTRL:   io_din = 16'(ctrl_q[i]);
            default:    io_din = 16'(pend_q[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= |(pend_q & ie_q);
  end

endmodule

// File: tb/tb_io_timer_bank.sv
module tb_io_timer_bank;
  import io_timer_bank_pkg::*;

  localparam int NCH = 2;
  localparam int BB  = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout;
  logic [15:0] io_din_a, io_din_b;
  logic        irq_a, irq_b;

  int compared = 0;
  int mismatched = 0;
  bit run = 1'b0;

  // Model state: index 0 = DIV 1 instance, index 1 = DIV 4 instance.
  int unsigned m_cnt [2][NCH];
  int unsigned m_rld [2][NCH];
  int unsigned m_ctl [2][NCH];
  int unsigned m_pnd [2][NCH];
  int unsigned m_irq [2];
  int unsigned m_edges [2];

  always #10 clk = ~clk;

  io_timer_bank #(.NCH(NCH), .WIDTH(16), .DIV(1), .BASE_BIT(BB)) dut_a (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din_a), .irq(irq_a));

  io_timer_bank #(.NCH(NCH), .WIDTH(16), .DIV(4), .BASE_BIT(BB)) dut_b (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din_b), .irq(irq_b));

  function automatic int div_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] adr(int ch, logic [1:0] r);
    logic [15:0] a;
    a = 16'h4000;
    a[3:2] = 2'(ch);
    a[1:0] = r;
    return a;
  endfunction

  task automatic chk(string nm, int unsigned act, int unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_irq[d] = 0;
      m_edges[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = 0; m_rld[d][c] = 0; m_ctl[d][c] = 0; m_pnd[d][c] = 0;
      end
    end
  endtask

  // One clock edge of the behavioural model, from the inputs presented to it.
  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      bit tick, nirq;
      m_edges[d]++;
      tick = (m_edges[d] % div_of(d)) == 0;
      nirq = 0;
      for (int c = 0; c < NCH; c++)
        if (m_pnd[d][c] != 0 && m_ctl[d][c][CTRL_IE]) nirq = 1;
      for (int c = 0; c < NCH; c++) begin
        bit w, ovf;
        int unsigned cnt, r;
        w   = io_wr && io_addr[BB] && (int'(io_addr[3:2]) == c);
        r   = io_addr[1:0];
        ovf = 0;
        cnt = m_cnt[d][c];
        if (tick && m_ctl[d][c][CTRL_EN]) begin
          if (cnt == 'hFFFF) begin ovf = 1; cnt = m_rld[d][c]; end
          else cnt = cnt + 1;
        end
        if (w && r == REG_COUNT) begin cnt = io_dout; ovf = 0; end
        m_cnt[d][c] = cnt;
        if (ovf && m_ctl[d][c][CTRL_ONESHOT]) m_ctl[d][c] = m_ctl[d][c] & ~(1 << CTRL_EN);
        if (w && r == REG_CTRL) m_ctl[d][c] = io_dout & 7;
        if (w && r == REG_RELOAD) m_rld[d][c] = io_dout;
        if (ovf) m_pnd[d][c] = 1;
        else if (w && r == REG_STATUS && io_dout[0]) m_pnd[d][c] = 0;
      end
      m_irq[d] = nirq;
    end
  endtask

  function automatic int unsigned model_read(int d, logic [15:0] a);
    int c;
    if (!a[BB]) return 0;
    c = int'(a[3:2]);
    if (c >= NCH) return 0;
    case (a[1:0])
      REG_COUNT:  return m_cnt[d][c];
      REG_RELOAD: return m_rld[d][c];
      REG_CTRL:   return m_ctl[d][c];
      default:    return m_pnd[d][c];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(int ch, logic [1:0] r, logic [15:0] v);
    io_wr = 1'b1; io_rd = 1'b0; io_addr = adr(ch, r); io_dout = v;
    step();
    io_wr = 1'b0;
  endtask

  task automatic peek(int d, logic [15:0] a, int unsigned exp, string nm);
    io_wr = 1'b0; io_rd = 1'b1; io_addr = a;
    #1;
    chk(nm, (d == 0) ? io_din_a : io_din_b, exp);
  endtask

  // Continuous comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("cmp_din_a", io_din_a, model_read(0, io_addr));
        chk("cmp_din_b", io_din_b, model_read(1, io_addr));
        chk("cmp_irq_a", irq_a, m_irq[0]);
        chk("cmp_irq_b", irq_b, m_irq[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0;
    model_reset();
    run = 1'b1;
    step(); step();
    reset = 1'b0;
    peek(0, adr(0, REG_COUNT), 0, "rst_count");
    peek(1, adr(1, REG_CTRL), 0, "rst_ctrl");
    chk("rst_irq", irq_a, 0);

    // Free-run: overflow on the 2nd tick, irq one cycle later.
    wr(0, REG_RELOAD, 16'hFFF0);
    wr(0, REG_COUNT, 16'hFFFE);
    wr(0, REG_CTRL, 16'h0005);
    step();
    peek(0, adr(0, REG_COUNT), 'hFFFF, "free_tick1");
    step();
    peek(0, adr(0, REG_COUNT), 'hFFF0, "free_reload");
    peek(0, adr(0, REG_STATUS), 1, "free_pend");
    chk("free_irq_lat", irq_a, 0);
    step();
    chk("free_irq", irq_a, 1);

    // One-shot on channel 1.
    wr(1, REG_RELOAD, 16'h1234);
    wr(1, REG_COUNT, 16'hFFFF);
    wr(1, REG_CTRL, 16'h0003);
    step();
    peek(0, adr(1, REG_COUNT), 'h1234, "os_count");
    peek(0, adr(1, REG_CTRL), 'h2, "os_ctrl");
    repeat (3) step();
    peek(0, adr(1, REG_COUNT), 'h1234, "os_hold");

    // COUNT write beats a coincident overflow.
    wr(0, REG_CTRL, 16'h0000);
    wr(0, REG_STATUS, 16'h0001);
    wr(0, REG_COUNT, 16'hFFFF);
    wr(0, REG_CTRL, 16'h0001);
    wr(0, REG_COUNT, 16'h0005);
    peek(0, adr(0, REG_COUNT), 'h0005, "prio_count");
    peek(0, adr(0, REG_STATUS), 0, "prio_pend");

    // PEND clear racing a PEND set.
    wr(0, REG_CTRL, 16'h0005);
    wr(0, REG_COUNT, 16'hFFFF);
    step();
    step();
    chk("race_irq_pre", irq_a, 1);
    wr(0, REG_COUNT, 16'hFFFF);
    wr(0, REG_STATUS, 16'h0001);
    peek(0, adr(0, REG_STATUS), 1, "race_pend");
    chk("race_irq", irq_a, 1);
    step();
    chk("race_irq_hold", irq_a, 1);

    // Prescaler and select decode.
    wr(0, REG_CTRL, 16'h0001);
    wr(1, REG_CTRL, 16'hFFF9);
    peek(0, adr(1, REG_CTRL), 1, "ctrl_trunc");
    wr(1, REG_COUNT, 16'h0100);
    wr(0, REG_COUNT, 16'h0100);
    repeat (8) step();
    peek(0, adr(0, REG_COUNT), 'h0108, "div1_ch0");
    peek(0, adr(1, REG_COUNT), 'h0109, "div1_ch1");
    peek(1, adr(0, REG_COUNT), 'h0102, "div4_ch0_8");
    repeat (4) step();
    peek(1, adr(0, REG_COUNT), 'h0103, "div4_ch0_12");
    peek(0, 16'h0000, 0, "nosel_a");
    peek(1, 16'h0000, 0, "nosel_b");
    wr(3, REG_COUNT, 16'h7777);
    peek(0, adr(3, REG_COUNT), 0, "ch3_a");
    peek(1, adr(3, REG_CTRL), 0, "ch3_b");

    // Asynchronous reset between edges.
    wr(0, REG_CTRL, 16'h0005);
    wr(0, REG_COUNT, 16'hFFFF);
    step(); step();
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        peek(0, adr(c, 2'(r)), 0, "arst_a");
        peek(1, adr(c, 2'(r)), 0, "arst_b");
      end
    chk("arst_irq_a", irq_a, 0);
    chk("arst_irq_b", irq_b, 0);
    step();
    reset = 1'b0;

    // First tick after reset lands DIV cycles later.
    wr(0, REG_CTRL, 16'h0001);
    step(); step();
    peek(1, adr(0, REG_COUNT), 0, "post_rst_b0");
    step();
    peek(1, adr(0, REG_COUNT), 1, "post_rst_b1");
    peek(0, adr(0, REG_COUNT), 3, "post_rst_a");
    step();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_timer_bank.md
IO_TIMER_BANK -- requirements
Module: io_timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of timer channels (legal 1..4).
REQ-002 SHALL have parameter WIDTH, default 16, meaning counter/reload width (legal 8..16).
REQ-003 SHALL have parameter DIV, default 1, meaning clock cycles per count tick (legal 1..65535).
REQ-004 SHALL have parameter BASE_BIT, default 14, meaning the io_addr bit that selects this block.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-007 SHALL have port io_rd, input, 1, meaning the CPU read strobe.
REQ-008 SHALL have port io_wr, input, 1, meaning the CPU write strobe.
REQ-009 SHALL have port io_addr, input, 16, meaning the CPU IO address.
REQ-010 SHALL have port io_dout, input, 16, meaning the CPU write data.
REQ-011 SHALL have port io_din, output, 16, meaning the read data, which is 0 when the block is not selected.
REQ-012 SHALL have port irq, output, 1, meaning the registered interrupt request.

Function
REQ-013 Select SHALL be sel = io_addr[BASE_BIT]; the channel is io_addr[3:2] and the register is io_addr[1:0] (0 COUNT, 1 RELOAD, 2 CTRL, 3 STATUS).
REQ-014 An access to a channel index >= NCH SHALL be ignored on write and SHALL read 0.
REQ-015 io_din SHALL be combinational from io_addr, with zero read latency, so it can be OR-merged on the CPU bus; unused upper bits SHALL read 0.
REQ-016 Reads SHALL have no side effects; io_rd is accepted but does not alter state.
REQ-017 CTRL bits SHALL be [0] EN, [1] ONESHOT, [2] IE; all other bits are ignored on write and read 0.
REQ-018 STATUS bit [0] SHALL be PEND; writing 1 to it clears PEND, and writing 0 has no effect.
REQ-019 The shared prescaler SHALL count 0..DIV-1 and assert a one-cycle tick when it wraps; with DIV=1, tick is asserted every cycle.
REQ-020 On a tick with EN=1, a channel SHALL increment COUNT modulo 2^WIDTH.
REQ-021 A tick with EN=1 and COUNT=all-ones SHALL cause an overflow event, which:
- loads COUNT from RELOAD;
- sets PEND;
- clears EN if ONESHOT=1.
REQ-022 A CPU write to COUNT SHALL take priority over a tick increment or reload in the same cycle; no overflow event occurs in that cycle.
REQ-023 A write to CTRL in the same cycle as an overflow event SHALL take effect, including EN, and the overflow's EN-clear SHALL be lost.
REQ-024 When a PEND clear and a PEND set occur in the same cycle, set SHALL win.
REQ-025 irq SHALL be registered as irq <= OR over channels of (PEND & IE), giving one cycle latency from the PEND/IE change.
REQ-026 A write to RELOAD SHALL NOT alter COUNT; the new value applies at the next overflow.
REQ-027 Written values SHALL be truncated to WIDTH bits.

Reset
REQ-028 Asserting reset SHALL immediately clear the following, regardless of clk or any in-flight tick:
- COUNT, RELOAD, CTRL and PEND of all channels;
- the prescaler;
- irq.
REQ-029 After reset deasserts, the first tick SHALL occur DIV cycles later.

Structure
REQ-030 The register offsets, CTRL/STATUS bit positions and the NCH maximum SHALL be constants in a shared package, common to RTL and bench.
REQ-031 One sub-module, timer_channel, SHALL hold the per-channel COUNT/RELOAD/CTRL/PEND logic.
REQ-032 The top SHALL hold the prescaler, the address decode, the read mux and the irq register.
REQ-033 The top SHALL instantiate timer_channel NCH times.

Verification
REQ-034 Free-run test: DIV=1, RELOAD=0xFFF0, COUNT=0xFFFE, CTRL=0x5. Required: an overflow on the 2nd tick, COUNT=0xFFF0, PEND=1, and irq=1 one cycle later.
REQ-035 One-shot test: CTRL=0x3, COUNT=0xFFFF, RELOAD=0x1234. Required: after one tick COUNT=0x1234, EN=0 (CTRL reads 0x2), and COUNT stays at 0x1234.
REQ-036 Write-priority test: write COUNT=0x0005 in the same cycle an overflow would occur. Required: COUNT=0x0005 and PEND unchanged.
REQ-037 Clear-race test: write STATUS=1 in the cycle PEND is set again. Required: PEND=1 and irq stays 1.
REQ-038 Prescaler and select test: DIV=4, two channels enabled. Required: COUNT advances once every 4 clk; an address with io_addr[BASE_BIT]=0 reads 0; channel index 3 with NCH=2 reads 0.
REQ-039 Async reset test: assert reset mid-count between clock edges. Required: io_din=0 for all registers and irq=0 before the next clk edge.
